// File: rtl/pat_mem_arbiter_pkg.sv
// ============================================================================
// Module      : pat_mem_arbiter_pkg
// Description : Shared types and defaults for the pattern memory arbiter:
//               arbiter state encoding, read-owner tag, doorbell defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pat_mem_arbiter_pkg;

  // Arbiter state records the last owner of the memory bus
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOST  = 2'd2
  } arb_state_e;

  // Which requester owns an in-flight read
  typedef enum logic {
    TAG_FETCH = 1'b0,
    TAG_HOST  = 1'b1
  } req_tag_e;

  // Doorbell defaults: a host write of c_start_code to word c_start_addr
  localparam int unsigned c_start_addr = 0;
  localparam logic [7:0]  c_start_code = 8'h77;

endpackage : pat_mem_arbiter_pkg

`default_nettype wire

// File: rtl/pat_mem_arbiter_if.sv
// ============================================================================
// Module      : pat_mem_arbiter_if
// Description : Bundle of the fetch port, host port, memory bus and doorbell
//               pulse of the pattern memory arbiter. The arbiter connects
//               through the slave modport; the surrounding logic (requesters
//               and memory) uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pat_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 256
);

  localparam int c_be_w = DATA_W / 8;

  // Fetch requester (read-only)
  logic              f_req;
  logic              f_lock;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  // Host requester (read/write)
  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [c_be_w-1:0] h_be;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  // Memory bus
  logic              mem_chip_select;
  logic              mem_clk_ena;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [c_be_w-1:0] mem_byte_enable;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  // Doorbell
  logic              frame_start;

  modport slave (
    input  f_req, f_lock, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  h_req, h_we, h_addr, h_wdata, h_be,
    output h_gnt, h_rvalid, h_rdata,
    output mem_chip_select, mem_clk_ena, mem_read, mem_write,
    output mem_addr, mem_byte_enable, mem_write_data,
    input  mem_read_data,
    output frame_start
  );

  modport master (
    output f_req, f_lock, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output h_req, h_we, h_addr, h_wdata, h_be,
    input  h_gnt, h_rvalid, h_rdata,
    input  mem_chip_select, mem_clk_ena, mem_read, mem_write,
    input  mem_addr, mem_byte_enable, mem_write_data,
    output mem_read_data,
    input  frame_start
  );

endinterface : pat_mem_arbiter_if

`default_nettype wire

// File: rtl/pat_mem_rd_tag_pipe.sv
// ============================================================================
// Module      : pat_mem_rd_tag_pipe
// Description : RD_LAT-deep valid+owner shift register. A read strobe enters
//               with its owner tag and emerges RD_LAT cycles later as the
//               owning port's rvalid. Reset drops everything in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pat_mem_rd_tag_pipe
  import pat_mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_valid,
  input  req_tag_e i_tag,
  output logic     o_f_rvalid,
  output logic     o_h_rvalid
);

  logic [RD_LAT-1:0] r_valid;
  req_tag_e          r_tag [RD_LAT];

  // Shift each read strobe and its owner one stage per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag[i] <= TAG_FETCH;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_tag[0]   <= i_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign o_f_rvalid = r_valid[RD_LAT-1] & (r_tag[RD_LAT-1] == TAG_FETCH);
  assign o_h_rvalid = r_valid[RD_LAT-1] & (r_tag[RD_LAT-1] == TAG_HOST);

endmodule : pat_mem_rd_tag_pipe

`default_nettype wire

// File: rtl/pat_mem_arbiter.sv
// ============================================================================
// Module      : pat_mem_arbiter
// Description : Shares the single-port pattern memory between the fetch
//               datapath (read-only, priority) and the host loader
//               (read/write). Registers the memory bus, routes read data
//               back to its owner and decodes the start doorbell.
// Config      : PAT_MEM_ARB_FAIRNESS_EN - when defined, the host is forced a
//               grant after MAX_WAIT fetch grants taken while it was waiting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pat_mem_arbiter
  import pat_mem_arbiter_pkg::*;
#(
  parameter int                ADDR_W     = 13,
  parameter int                DATA_W     = 256,
  parameter int                RD_LAT     = 2,
  parameter int                MAX_WAIT   = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(c_start_addr),
  parameter logic [7:0]        START_CODE = c_start_code
) (
  input logic              clk,
  input logic              rst_n,
  pat_mem_arbiter_if.slave bus
);

  localparam int c_be_w = DATA_W / 8;

  logic              w_f_gnt;
  logic              w_h_gnt;
  logic              w_force_host;

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;

  logic              r_mem_clk_ena;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [c_be_w-1:0] r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;
  req_tag_e          r_mem_tag;
  logic              r_frame_start;

  logic              w_f_rvalid;
  logic              w_h_rvalid;

`ifdef PAT_MEM_ARB_FAIRNESS_EN
  localparam int                  c_wait_w   = $clog2(MAX_WAIT + 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);

  logic [c_wait_w-1:0] r_wait_cnt;

  // Count fetch grants taken while the host waits unlocked; clear when the host gets in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_h_gnt) begin
      r_wait_cnt <= '0;
    end else if (w_f_gnt && bus.h_req && !bus.f_lock && (r_wait_cnt != c_wait_max)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // A lock always beats fairness
  assign w_force_host = bus.h_req & ~bus.f_lock & (r_wait_cnt == c_wait_max);
`else
  assign w_force_host = 1'b0;
`endif

  // Grant: fetch first, host only when fetch is absent/unlocked or fairness forces it
  always_comb begin
    w_f_gnt = bus.f_req & ~w_force_host;
    w_h_gnt = bus.h_req & ~bus.f_lock & (~bus.f_req | w_force_host);
  end

  // Owner state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Owner next-state: follow whichever side was granted, hold FETCH while it locks
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_f_gnt)      w_state_nxt = ST_FETCH;
        else if (w_h_gnt) w_state_nxt = ST_HOST;
      end
      ST_FETCH: begin
        if (w_h_gnt)                       w_state_nxt = ST_HOST;
        else if (bus.f_req || bus.f_lock)  w_state_nxt = ST_FETCH;
        else                               w_state_nxt = ST_IDLE;
      end
      ST_HOST: begin
        if (w_f_gnt)      w_state_nxt = ST_FETCH;
        else if (w_h_gnt) w_state_nxt = ST_HOST;
        else              w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Register the accepted access onto the memory bus and decode the doorbell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_clk_ena <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_be      <= '0;
      r_mem_wdata   <= '0;
      r_mem_tag     <= TAG_FETCH;
      r_frame_start <= 1'b0;
    end else begin
      r_mem_clk_ena <= 1'b1;
      r_mem_read    <= w_f_gnt | (w_h_gnt & ~bus.h_we);
      r_mem_write   <= w_h_gnt & bus.h_we;
      r_frame_start <= w_h_gnt & bus.h_we & (bus.h_addr == START_ADDR) &
                       bus.h_be[0] & (bus.h_wdata[7:0] == START_CODE);
      if (w_f_gnt) begin
        r_mem_addr <= bus.f_addr;
        r_mem_be   <= '1;
        r_mem_tag  <= TAG_FETCH;
      end else if (w_h_gnt) begin
        r_mem_addr <= bus.h_addr;
        r_mem_tag  <= TAG_HOST;
        if (bus.h_we) begin
          r_mem_be    <= bus.h_be;
          r_mem_wdata <= bus.h_wdata;
        end else begin
          r_mem_be    <= '1;
        end
      end
    end
  end

  pat_mem_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (r_mem_read),
    .i_tag      (r_mem_tag),
    .o_f_rvalid (w_f_rvalid),
    .o_h_rvalid (w_h_rvalid)
  );

  assign bus.f_gnt           = w_f_gnt;
  assign bus.h_gnt           = w_h_gnt;
  assign bus.f_rvalid        = w_f_rvalid;
  assign bus.h_rvalid        = w_h_rvalid;
  assign bus.f_rdata         = bus.mem_read_data;
  assign bus.h_rdata         = bus.mem_read_data;
  assign bus.mem_clk_ena     = r_mem_clk_ena;
  assign bus.mem_read        = r_mem_read;
  assign bus.mem_write       = r_mem_write;
  assign bus.mem_chip_select = r_mem_read | r_mem_write;
  assign bus.mem_addr        = r_mem_addr;
  assign bus.mem_byte_enable = r_mem_be;
  assign bus.mem_write_data  = r_mem_wdata;
  assign bus.frame_start     = r_frame_start;

endmodule : pat_mem_arbiter

`default_nettype wire

// File: tb/tb_pat_mem_arbiter.sv
// ============================================================================
// Module      : tb_pat_mem_arbiter
// Description : Self-checking bench for pat_mem_arbiter. Reads are tracked in
//               a scoreboard (owner, data, arrival cycle) and checked when
//               rvalid appears. Honours PAT_MEM_ARB_FAIRNESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pat_mem_arbiter;
  import pat_mem_arbiter_pkg::*;

  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 256;
  localparam int BE_W     = DATA_W / 8;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 8;
`ifdef PAT_MEM_ARB_FAIRNESS_EN
  localparam int EXP_FIRST_H = MAX_WAIT + 1;
`else
  localparam int EXP_FIRST_H = 0;
`endif

  typedef struct {
    logic              is_host;
    logic [DATA_W-1:0] data;
    int                cyc;
  } sb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  sb_t  sb_q[$];
  sb_t  mon_e;

  pat_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pat_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data is a fixed function of the address issued RD_LAT cycles ago
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(a);
    return {8{w}};
  endfunction

  logic [ADDR_W-1:0] mem_pipe [RD_LAT];
  always @(posedge clk) begin
    mem_pipe[0] <= bus.mem_addr;
    for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign bus.mem_read_data = pat(mem_pipe[RD_LAT-1]);

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_read(input logic is_host, input logic [ADDR_W-1:0] a);
    sb_t e;
    e.is_host = is_host;
    e.data    = pat(a);
    e.cyc     = cyc + 1 + RD_LAT;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.f_req   = 1'b0;
    bus.f_lock  = 1'b0;
    bus.f_addr  = '0;
    bus.h_req   = 1'b0;
    bus.h_we    = 1'b0;
    bus.h_addr  = '0;
    bus.h_wdata = '0;
    bus.h_be    = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {bus.f_gnt, bus.f_rvalid, bus.h_gnt, bus.h_rvalid, bus.mem_chip_select,
                         bus.mem_clk_ena, bus.mem_read, bus.mem_write, bus.frame_start}, '0);
    chk({tag, "_addr"},  bus.mem_addr, '0);
    chk({tag, "_be"},    bus.mem_byte_enable, '0);
    chk({tag, "_wdata"}, bus.mem_write_data, '0);
  endtask

  // Scoreboard monitor: every rvalid must match the oldest outstanding read
  always @(negedge clk) begin
    if (bus.f_rvalid || bus.h_rvalid) begin
      if (sb_q.size() == 0) begin
        chk("rvalid_unexpected", {bus.f_rvalid, bus.h_rvalid}, '0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rvalid_port", {bus.f_rvalid, bus.h_rvalid}, mon_e.is_host ? 2'b01 : 2'b10);
        chk("rdata", mon_e.is_host ? bus.h_rdata : bus.f_rdata, mon_e.data);
        chk("rvalid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    int first_h;
    int both_gnt;
    int n_rv;

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");

    // Release; clock enable rises on the first edge afterwards
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("clk_ena_before_edge", bus.mem_clk_ena, 1'b0);
    @(negedge clk);
    #1;
    chk("clk_ena_after_edge", bus.mem_clk_ena, 1'b1);

    // 1: single fetch read of address 5
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 13'd5;
    #1;
    chk("t1_f_gnt", bus.f_gnt, 1'b1);
    chk("t1_h_gnt", bus.h_gnt, 1'b0);
    push_read(1'b0, 13'd5);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t1_mem_read", bus.mem_read, 1'b1);
    chk("t1_mem_write", bus.mem_write, 1'b0);
    chk("t1_mem_cs", bus.mem_chip_select, 1'b1);
    chk("t1_mem_addr", bus.mem_addr, 13'd5);
    chk("t1_mem_be", bus.mem_byte_enable, {BE_W{1'b1}});
    repeat (4) @(negedge clk);

    // 2: contention, fetch first, host on the first fetch-free cycle
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 13'd7;
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 13'd9;
    #1;
    chk("t2_f_gnt", bus.f_gnt, 1'b1);
    chk("t2_h_gnt_blocked", bus.h_gnt, 1'b0);
    push_read(1'b0, 13'd7);
    @(negedge clk);
    bus.f_req = 1'b0;
    #1;
    chk("t2_h_gnt", bus.h_gnt, 1'b1);
    chk("t2_f_gnt_idle", bus.f_gnt, 1'b0);
    push_read(1'b1, 13'd9);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t2_mem_read", bus.mem_read, 1'b1);
    chk("t2_mem_addr", bus.mem_addr, 13'd9);
    repeat (5) @(negedge clk);

    // 3: lock holds the host off for 10 cycles, host write when it drops
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.f_lock = 1'b1;
      bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 13'd3;
      bus.h_wdata = {{(DATA_W-8){1'b1}}, 8'h12}; bus.h_be = 32'h0000_FFFF;
      #1;
      chk("t3_lock_h_gnt", bus.h_gnt, 1'b0);
    end
    @(negedge clk);
    bus.f_lock = 1'b0;
    #1;
    chk("t3_unlock_h_gnt", bus.h_gnt, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t3_mem_write", bus.mem_write, 1'b1);
    chk("t3_mem_read", bus.mem_read, 1'b0);
    chk("t3_mem_addr", bus.mem_addr, 13'd3);
    chk("t3_mem_be", bus.mem_byte_enable, 32'h0000_FFFF);
    chk("t3_mem_wdata", bus.mem_write_data, {{(DATA_W-8){1'b1}}, 8'h12});
    chk("t3_no_frame_start", bus.frame_start, 1'b0);
    repeat (2) @(negedge clk);

    // 4: continuous fetch against a waiting host
    first_h  = 0;
    both_gnt = 0;
    for (int i = 1; i <= 12 && first_h == 0; i++) begin
      @(negedge clk);
      bus.f_req = 1'b1; bus.f_addr = ADDR_W'(100 + i);
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 13'd42;
      #1;
      if (bus.f_gnt && bus.h_gnt) both_gnt++;
      if (bus.h_gnt) begin
        first_h = i;
        push_read(1'b1, 13'd42);
      end else if (bus.f_gnt) begin
        push_read(1'b0, ADDR_W'(100 + i));
      end
    end
    @(negedge clk);
    idle_inputs();
    chk("t4_first_host_grant", first_h, EXP_FIRST_H);
    chk("t4_one_grant_per_cycle", both_gnt, 0);
    repeat (5) @(negedge clk);

    // 5: doorbell write pulses once; wrong code and host read do not
    @(negedge clk);
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 13'd0;
    bus.h_wdata = {{(DATA_W-8){1'b0}}, 8'h77}; bus.h_be = {BE_W{1'b1}};
    #1;
    chk("t5_h_gnt", bus.h_gnt, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t5_frame_start", bus.frame_start, 1'b1);
    chk("t5_mem_write", bus.mem_write, 1'b1);
    @(negedge clk);
    #1;
    chk("t5_frame_start_one_cycle", bus.frame_start, 1'b0);
    @(negedge clk);
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 13'd0;
    bus.h_wdata = {{(DATA_W-8){1'b0}}, 8'h76}; bus.h_be = {BE_W{1'b1}};
    #1;
    chk("t5_h_gnt_76", bus.h_gnt, 1'b1);
    @(negedge clk);
    bus.h_we = 1'b0; bus.h_wdata = {{(DATA_W-8){1'b0}}, 8'h77};
    #1;
    chk("t5_no_pulse_76", bus.frame_start, 1'b0);
    push_read(1'b1, 13'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t5_no_pulse_read", bus.frame_start, 1'b0);
    repeat (5) @(negedge clk);
    chk("sb_drained_pre_reset", sb_q.size(), 0);

    // 6: reset while a read is in flight drops it
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 13'd11;
    #1;
    chk("t6_f_gnt", bus.f_gnt, 1'b1);
    push_read(1'b0, 13'd11);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("t6_mem_read", bus.mem_read, 1'b1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk_all_zero("t6_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_rv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (bus.f_rvalid || bus.h_rvalid) n_rv++;
    end
    chk("t6_no_rvalid_after_reset", n_rv, 0);
    chk("sb_drained_end", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pat_mem_arbiter

`default_nettype wire
